// File: rtl/audio_clk_pkg.sv
// Shared constants and helpers for the codec serial-clock generator.
// half_div() gives iCLK cycles per BCK half-period; half_ok() checks that the division is exact.
package audio_clk_pkg;

    localparam int DEF_RATE0 = 32'sd48000;
    localparam int DEF_RATE1 = 32'sd32000;
    localparam int DEF_RATE2 = 32'sd16000;
    localparam int DEF_RATE3 = 32'sd8000;

    localparam logic MODE_LJ  = 1'b0;
    localparam logic MODE_DSP = 1'b1;

    function automatic int half_div(input int ref_hz, input int rate, input int dw, input int ch);
        return ref_hz / (rate * dw * ch * 32'sd2);
    endfunction

    function automatic bit half_ok(input int ref_hz, input int rate, input int dw, input int ch);
        int den;
        den = rate * dw * ch * 32'sd2;
        if (den <= 32'sd0) begin
            return 1'b0;
        end
        return ((ref_hz % den) == 32'sd0) && ((ref_hz / den) >= 32'sd2);
    endfunction

endpackage

// File: rtl/audio_clk_div.sv
// Programmable half-period counter: o_tick marks the last cycle of each BCK half-period.
module audio_clk_div
    import audio_clk_pkg::*;
#(
    parameter int HW = 6
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          i_clear,
    input  logic [HW-1:0] i_half,
    output logic          o_tick
);

    logic [HW-1:0] r_cnt;
    logic          w_last;

    // A half value that shrinks mid-count still terminates on the next cycle.
    assign w_last = (r_cnt >= (i_half - HW'(1'b1)));
    assign o_tick = w_last & ~i_clear;

    // Count 0..half-1; clear parks the counter at the start of a half-period.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + HW'(1'b1);
        end
    end

endmodule

// File: rtl/audio_clock_gen.sv
// BCK/LRCK generator for the codec serial path, plus the shift strobes and slot/bit indices.
// LRCK and the indices move only on a BCK fall; rate and mode changes wait for a frame boundary.
module audio_clock_gen
    import audio_clk_pkg::*;
#(
    parameter int REF_CLK     = 32'sd18432000,
    parameter int DATA_WIDTH  = 32'sd16,
    parameter int CHANNEL_NUM = 32'sd2,
    parameter int RATE0       = DEF_RATE0,
    parameter int RATE1       = DEF_RATE1,
    parameter int RATE2       = DEF_RATE2,
    parameter int RATE3       = DEF_RATE3,
    localparam int BIT_W      = $clog2(DATA_WIDTH),
    localparam int CH_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iEN,
    input  logic [1:0]       iRATE_SEL,
    input  logic             iMODE,
    output logic             oAUD_BCK,
    output logic             oAUD_LRCK,
    output logic             oBCK_FALL,
    output logic             oBCK_RISE,
    output logic             oFRAME_START,
    output logic [BIT_W-1:0] oBIT_IDX,
    output logic [CH_W-1:0]  oCH_IDX
);

    localparam int FRAME_BITS = DATA_WIDTH * CHANNEL_NUM;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int HALF0      = half_div(REF_CLK, RATE0, DATA_WIDTH, CHANNEL_NUM);
    localparam int HALF1      = half_div(REF_CLK, RATE1, DATA_WIDTH, CHANNEL_NUM);
    localparam int HALF2      = half_div(REF_CLK, RATE2, DATA_WIDTH, CHANNEL_NUM);
    localparam int HALF3      = half_div(REF_CLK, RATE3, DATA_WIDTH, CHANNEL_NUM);
    localparam int HALF01     = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int HALF23     = (HALF2 > HALF3) ? HALF2 : HALF3;
    localparam int HALF_MAX   = (HALF01 > HALF23) ? HALF01 : HALF23;
    localparam int HW         = $clog2(HALF_MAX + 32'sd1);

    localparam bit CFG_OK = half_ok(REF_CLK, RATE0, DATA_WIDTH, CHANNEL_NUM)
                         && half_ok(REF_CLK, RATE1, DATA_WIDTH, CHANNEL_NUM)
                         && half_ok(REF_CLK, RATE2, DATA_WIDTH, CHANNEL_NUM)
                         && half_ok(REF_CLK, RATE3, DATA_WIDTH, CHANNEL_NUM)
                         && ((CHANNEL_NUM == 32'sd2) || (CHANNEL_NUM == 32'sd4) || (CHANNEL_NUM == 32'sd8));

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("audio_clock_gen: every rate must divide REF_CLK into an integer half-period >= 2");
        end
    endgenerate

    logic             r_bck;
    logic             r_lrck;
    logic             r_fall;
    logic             r_rise;
    logic             r_fs;
    logic [BIT_W-1:0] r_bit_idx;
    logic [CH_W-1:0]  r_ch_idx;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [1:0]       r_rate;
    logic             r_mode;
    logic             r_live;

    logic [1:0]       w_rate;
    logic [HW-1:0]    w_half;
    logic             w_tick;
    logic             w_wrap;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [BIT_W-1:0] w_bit_idx_nxt;
    logic [CH_W-1:0]  w_ch_nxt;
    logic             w_mode_nxt;
    logic             w_lrck_nxt;

    // Half-period select; the first cycle out of idle reads the rate input directly.
    always_comb begin
        w_rate = r_live ? r_rate : iRATE_SEL;
        case (w_rate)
            2'd0:    w_half = HW'(HALF0);
            2'd1:    w_half = HW'(HALF1);
            2'd2:    w_half = HW'(HALF2);
            2'd3:    w_half = HW'(HALF3);
            default: w_half = HW'(HALF0);
        endcase
    end

    audio_clk_div #(
        .HW (HW)
    ) u_div (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .i_clear (~iEN),
        .i_half  (w_half),
        .o_tick  (w_tick)
    );

    // Frame position and LRCK level that take effect on the next BCK fall.
    always_comb begin
        w_wrap = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
        if (w_wrap) begin
            w_bit_cnt_nxt = '0;
            w_mode_nxt    = iMODE;
        end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1'b1);
            w_mode_nxt    = r_mode;
        end
        if (r_bit_idx == '0) begin
            w_bit_idx_nxt = BIT_W'(DATA_WIDTH - 1);
        end else begin
            w_bit_idx_nxt = r_bit_idx - BIT_W'(1'b1);
        end
        if (w_wrap) begin
            w_ch_nxt = '0;
        end else if (r_bit_idx == '0) begin
            w_ch_nxt = r_ch_idx + CH_W'(1'b1);
        end else begin
            w_ch_nxt = r_ch_idx;
        end
        case (w_mode_nxt)
            MODE_LJ:  w_lrck_nxt = (w_bit_cnt_nxt < CNT_W'(FRAME_BITS / 2));
            MODE_DSP: w_lrck_nxt = (w_bit_cnt_nxt == '0);
            default:  w_lrck_nxt = 1'b0;
        endcase
    end

    // BCK, strobes, indices and the active rate/mode, all advanced on divider ticks.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_bck     <= 1'b0;
            r_lrck    <= 1'b0;
            r_fall    <= 1'b0;
            r_rise    <= 1'b0;
            r_fs      <= 1'b0;
            r_bit_idx <= '0;
            r_ch_idx  <= '0;
            r_bit_cnt <= CNT_W'(FRAME_BITS - 1);
            r_rate    <= 2'd0;
            r_mode    <= MODE_LJ;
            r_live    <= 1'b0;
        end else if (!iEN) begin
            r_bck     <= 1'b0;
            r_lrck    <= 1'b0;
            r_fall    <= 1'b0;
            r_rise    <= 1'b0;
            r_fs      <= 1'b0;
            r_bit_idx <= '0;
            r_ch_idx  <= '0;
            r_bit_cnt <= CNT_W'(FRAME_BITS - 1);
            r_rate    <= iRATE_SEL;
            r_mode    <= iMODE;
            r_live    <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            r_rise <= 1'b0;
            r_fs   <= 1'b0;
            r_live <= 1'b1;
            if (!r_live) begin
                r_rate <= iRATE_SEL;
            end
            if (w_tick) begin
                r_bck <= ~r_bck;
                if (!r_bck) begin
                    r_rise <= 1'b1;
                end else begin
                    r_fall    <= 1'b1;
                    r_fs      <= w_wrap;
                    r_bit_cnt <= w_bit_cnt_nxt;
                    r_bit_idx <= w_bit_idx_nxt;
                    r_ch_idx  <= w_ch_nxt;
                    r_lrck    <= w_lrck_nxt;
                    if (w_wrap) begin
                        r_rate <= iRATE_SEL;
                        r_mode <= iMODE;
                    end
                end
            end
        end
    end

    assign oAUD_BCK     = r_bck;
    assign oAUD_LRCK    = r_lrck;
    assign oBCK_FALL    = r_fall;
    assign oBCK_RISE    = r_rise;
    assign oFRAME_START = r_fs;
    assign oBIT_IDX     = r_bit_idx;
    assign oCH_IDX      = r_ch_idx;

endmodule

// File: tb/tb_audio_clock_gen.sv
// Directed bench: a stereo default instance and a 4-slot DSP instance, compared cycle by cycle
// against a timing model written from cycle counts since reset release or enable.
module tb_audio_clock_gen;

    logic       clk;
    logic       rst_n;
    logic       en_a, en_b;
    logic [1:0] rate_a, rate_b;
    logic       mode_a, mode_b;

    logic       a_bck, a_lrck, a_fall, a_rise, a_fs;
    logic [3:0] a_bit;
    logic [0:0] a_ch;
    logic       b_bck, b_lrck, b_fall, b_rise, b_fs;
    logic [3:0] b_bit;
    logic [1:0] b_ch;

    int n_total = 0;
    int n_bad   = 0;
    int nf;

    wire [11:0] va = {a_bck, a_lrck, a_fall, a_rise, a_fs, a_bit, 2'b00, a_ch};
    wire [11:0] vb = {b_bck, b_lrck, b_fall, b_rise, b_fs, b_bit, 1'b0, b_ch};

    audio_clock_gen dut_a (
        .iCLK         (clk),
        .iRST_N       (rst_n),
        .iEN          (en_a),
        .iRATE_SEL    (rate_a),
        .iMODE        (mode_a),
        .oAUD_BCK     (a_bck),
        .oAUD_LRCK    (a_lrck),
        .oBCK_FALL    (a_fall),
        .oBCK_RISE    (a_rise),
        .oFRAME_START (a_fs),
        .oBIT_IDX     (a_bit),
        .oCH_IDX      (a_ch)
    );

    audio_clock_gen #(
        .CHANNEL_NUM (4),
        .RATE1       (24000),
        .RATE2       (12000),
        .RATE3       (6000)
    ) dut_b (
        .iCLK         (clk),
        .iRST_N       (rst_n),
        .iEN          (en_b),
        .iRATE_SEL    (rate_b),
        .iMODE        (mode_b),
        .oAUD_BCK     (b_bck),
        .oAUD_LRCK    (b_lrck),
        .oBCK_FALL    (b_fall),
        .oBCK_RISE    (b_rise),
        .oFRAME_START (b_fs),
        .oBIT_IDX     (b_bit),
        .oCH_IDX      (b_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got 0x%0h want 0x%0h", tag, $time, act, exp);
        end
    endtask

    // Expected {bck,lrck,fall,rise,fs,bit_idx[3:0],ch_idx[2:0]} c cycles after start, 16-bit slots.
    function automatic logic [11:0] expv(input int c, input int half, input int chn, input bit mode);
        int per, fb, n, bi, ci;
        logic bck, lr, fa, ri, fs;
        per = 2 * half;
        fb  = 16 * chn;
        bck = ((c / half) % 2) == 1;
        ri  = (c % per) == half;
        fa  = (c > 0) && ((c % per) == 0);
        if (c < per) begin
            lr = 1'b0; fs = 1'b0; bi = 0; ci = 0;
        end else begin
            n  = (c - per) / per;
            fs = fa && ((n % fb) == 0);
            bi = 15 - (n % 16);
            ci = (n / 16) % chn;
            lr = mode ? ((n % fb) == 0) : ((n % fb) < (fb / 2));
        end
        return {bck, lr, fa, ri, fs, 4'(bi), 3'(ci)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        en_a   = 1'b1;  rate_a = 2'd0;  mode_a = 1'b0;
        en_b   = 1'b1;  rate_b = 2'd0;  mode_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_a", va, 0);
        check_val("reset_b", vb, 0);

        // Default stereo LJ at 48 kHz, and 4-slot DSP frame sync alongside it.
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 800; c++) begin
            tick();
            check_val("lj48_a", va, expv(c, 6, 2, 1'b0));
            check_val("dsp4_b", vb, expv(c, 3, 4, 1'b1));
        end

        // Asynchronous reset mid-frame, then the same start-up timing again.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_a", va, 0);
        check_val("async_rst_b", vb, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            tick();
            check_val("rerun_a", va, expv(c, 6, 2, 1'b0));
            check_val("rerun_b", vb, expv(c, 3, 4, 1'b1));
        end

        // 8 kHz selected from reset: period 72, frame 2304, 32 falls per frame.
        @(negedge clk);
        rst_n  = 1'b0;
        rate_a = 2'd3;
        @(negedge clk);
        rst_n = 1'b1;
        nf = 0;
        for (int c = 1; c <= 2400; c++) begin
            tick();
            check_val("r8k_a", va, expv(c, 36, 2, 1'b0));
            check_val("r8k_b", vb, expv(c, 3, 4, 1'b1));
            if (c >= 72 && c < 2376 && a_fall) nf++;
        end
        check_val("r8k_falls", nf, 32);

        // Enable dropped mid-frame: idle on the next cycle and held there.
        en_a   = 1'b0;
        rate_a = 2'd0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("en_off_a", va, 0);
        end

        // Re-enable at 48 kHz, switch to 32 kHz at bit 10 of frame 1, then a change and its reversal.
        en_a = 1'b1;
        for (int c = 1; c <= 2600; c++) begin
            if (c == 520)  rate_a = 2'd1;
            if (c == 1400) rate_a = 2'd2;
            if (c == 1500) rate_a = 2'd1;
            tick();
            check_val("rate_sw_a", va, (c <= 780) ? expv(c, 6, 2, 1'b0) : expv(c - 762, 9, 2, 1'b0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
